// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshakes on both sides,
// zero/parity flags on the result and a saturating count of completed operations.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             s_valid_in,
  output logic             s_ready_out,
  input  logic [2:0]       op_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             m_valid_out,
  input  logic             m_ready_in,
  output logic [WIDTH-1:0] y_out,
  output logic             zero_out,
  output logic             parity_out,
  output logic [CNT_W-1:0] count_out
);

  localparam logic [2:0] OP_NOT  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             s1_valid;
  logic [2:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] result;

  logic s2_adv;
  logic s1_adv;
  logic accept;
  logic complete;

  // Stage 2 is the output register, so its valid is m_valid_out itself.
  assign s2_adv      = !m_valid_out || m_ready_in;
  assign s1_adv      = !s1_valid || s2_adv;
  assign s_ready_out = !rst_in && s1_adv;
  assign accept      = s_valid_in && s_ready_out;
  assign complete    = m_valid_out && m_ready_in;

  always_comb begin
    result = '0;
    case (s1_op)
      OP_NOT:  result = ~s1_a;
      OP_AND:  result = s1_a & s1_b;
      OP_OR:   result = s1_a | s1_b;
      OP_XOR:  result = s1_a ^ s1_b;
      OP_NAND: result = ~(s1_a & s1_b);
      OP_NOR:  result = ~(s1_a | s1_b);
      OP_XNOR: result = ~(s1_a ^ s1_b);
      default: result = s1_a;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (s1_adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_op <= op_in;
        s1_a  <= a_in;
        s1_b  <= b_in;
      end
    end
  end

  // Result fields only load with a real operation so they keep the last completed value.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      m_valid_out <= 1'b0;
      y_out       <= '0;
      zero_out    <= 1'b0;
      parity_out  <= 1'b0;
    end else if (s2_adv) begin
      m_valid_out <= s1_valid;
      if (s1_valid) begin
        y_out      <= result;
        zero_out   <= (result == '0);
        parity_out <= ^result;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_out <= '0;
    end else if (complete && (count_out != CNT_MAX)) begin
      count_out <= count_out + 1'b1;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed-vector bench for logic_unit_pipe: a CNT_W=4 instance for saturation and a
// default-parameter instance driven in lockstep for the wide counter.
module tb_logic_unit_pipe;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       s_valid_in;
  logic [2:0] op_in;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       m_ready_in;

  logic        s_ready_out, m_valid_out, zero_out, parity_out;
  logic [7:0]  y_out;
  logic [3:0]  count_out;

  logic        s_ready16, m_valid16, zero16, parity16;
  logic [7:0]  y16;
  logic [15:0] count16;

  int check_count = 0;
  int error_count = 0;

  logic [7:0] sweep_exp [8] = '{8'h5A, 8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'hA5};

  always #5 clk_in = ~clk_in;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .s_valid_in(s_valid_in), .s_ready_out(s_ready_out),
    .op_in(op_in), .a_in(a_in), .b_in(b_in), .m_valid_out(m_valid_out),
    .m_ready_in(m_ready_in), .y_out(y_out), .zero_out(zero_out),
    .parity_out(parity_out), .count_out(count_out)
  );

  logic_unit_pipe dut16 (
    .clk_in(clk_in), .rst_in(rst_in), .s_valid_in(s_valid_in), .s_ready_out(s_ready16),
    .op_in(op_in), .a_in(a_in), .b_in(b_in), .m_valid_out(m_valid16),
    .m_ready_in(m_ready_in), .y_out(y16), .zero_out(zero16),
    .parity_out(parity16), .count_out(count16)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then return 1ns after the clock edge that samples them.
  task automatic applyStimulus(input logic valid, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    s_valid_in = valid;
    op_in      = op;
    a_in       = a;
    b_in       = b;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    rst_in = 1'b1; s_valid_in = 1'b0; op_in = '0; a_in = '0; b_in = '0; m_ready_in = 1'b1;
    applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
    applyStimulus(1'b1, 3'd1, 8'hFF, 8'hFF);
    checkOutput("rst_ready", s_ready_out, 0);
    checkOutput("rst_mvalid", m_valid_out, 0);
    checkOutput("rst_y", y_out, 0);
    checkOutput("rst_zero", zero_out, 0);
    checkOutput("rst_parity", parity_out, 0);
    checkOutput("rst_count", count_out, 0);
    rst_in = 1'b0;
    s_valid_in = 1'b0;
    #1;
    checkOutput("post_rst_ready", s_ready_out, 1);

    // Single AND: visible two cycles after acceptance, counted on its handshake.
    applyStimulus(1'b1, 3'd1, 8'hF0, 8'h3C);
    checkOutput("and_lat1_mvalid", m_valid_out, 0);
    applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
    checkOutput("and_mvalid", m_valid_out, 1);
    checkOutput("and_y", y_out, 8'h30);
    checkOutput("and_zero", zero_out, 0);
    checkOutput("and_parity", parity_out, 0);
    applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
    checkOutput("and_count", count_out, 1);
    checkOutput("and_done_mvalid", m_valid_out, 0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 3'(i), 8'hA5, 8'h0F);
      if (i > 0) begin
        checkOutput($sformatf("sweep_mvalid%0d", i - 1), m_valid_out, 1);
        checkOutput($sformatf("sweep_y%0d", i - 1), y_out, sweep_exp[i - 1]);
      end
    end
    applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
    checkOutput("sweep_mvalid7", m_valid_out, 1);
    checkOutput("sweep_y7", y_out, sweep_exp[7]);
    applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
    checkOutput("sweep_drain_mvalid", m_valid_out, 0);
    checkOutput("sweep_count", count_out, 9);

    applyStimulus(1'b1, 3'd3, 8'h77, 8'h77);
    applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
    checkOutput("xor0_y", y_out, 8'h00);
    checkOutput("xor0_zero", zero_out, 1);
    checkOutput("xor0_parity", parity_out, 0);
    applyStimulus(1'b1, 3'd7, 8'h01, 8'hFF);
    applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
    checkOutput("pass_y", y_out, 8'h01);
    checkOutput("pass_zero", zero_out, 0);
    checkOutput("pass_parity", parity_out, 1);
    applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
    checkOutput("pass_count", count_out, 11);

    // Backpressure: two ops fill the pipe, the third waits until m_ready_in returns.
    m_ready_in = 1'b0;
    applyStimulus(1'b1, 3'd2, 8'h10, 8'h01);
    applyStimulus(1'b1, 3'd1, 8'hFF, 8'h3C);
    checkOutput("bp_mvalid", m_valid_out, 1);
    checkOutput("bp_y", y_out, 8'h11);
    s_valid_in = 1'b1; op_in = 3'd6; a_in = 8'h0F; b_in = 8'h0F;
    #1;
    checkOutput("bp_ready_low", s_ready_out, 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 3'd6, 8'h0F, 8'h0F);
      checkOutput("bp_hold_mvalid", m_valid_out, 1);
      checkOutput("bp_hold_y", y_out, 8'h11);
      checkOutput("bp_hold_parity", parity_out, 0);
    end
    m_ready_in = 1'b1;
    #1;
    checkOutput("bp_ready_back", s_ready_out, 1);
    applyStimulus(1'b1, 3'd6, 8'h0F, 8'h0F);
    checkOutput("bp_second_y", y_out, 8'h3C);
    applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
    checkOutput("bp_third_mvalid", m_valid_out, 1);
    checkOutput("bp_third_y", y_out, 8'hFF);
    applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
    checkOutput("bp_empty_mvalid", m_valid_out, 0);
    checkOutput("bp_count", count_out, 14);

    // Reset with two operations in flight discards both.
    applyStimulus(1'b1, 3'd0, 8'h00, 8'h00);
    applyStimulus(1'b1, 3'd0, 8'hFF, 8'h00);
    checkOutput("mid_pre_mvalid", m_valid_out, 1);
    rst_in = 1'b1;
    s_valid_in = 1'b0;
    #1;
    checkOutput("mid_rst_ready", s_ready_out, 0);
    applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
    rst_in = 1'b0;
    checkOutput("mid_mvalid", m_valid_out, 0);
    checkOutput("mid_count", count_out, 0);
    checkOutput("mid_count16", count16, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
      checkOutput("mid_no_stale", m_valid_out, 0);
    end
    checkOutput("mid_count_after", count_out, 0);

    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 3'd7, 8'(i), 8'h00);
      if (i == 15) checkOutput("sat_count14", count_out, 14);
    end
    applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
    checkOutput("sat_last_y", y_out, 8'h10);
    applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
    checkOutput("sat_count", count_out, 4'hF);
    checkOutput("sat_count16", count16, 17);
    checkOutput("sat_y16", y16, 8'h10);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
